// File: rtl/syn_pipeline_ctrl_pkg.sv
// Shared constants, state encoding and the register-match helper for the
// pipeline hazard controller.
package syn_pipeline_ctrl_pkg;

  localparam logic [1:0] MUX_EX_REDIR_A_OLD = 2'd0;
  localparam logic [1:0] MUX_EX_REDIR_A_EX  = 2'd1;
  localparam logic [1:0] MUX_EX_REDIR_A_DM  = 2'd2;
  localparam logic [1:0] MUX_EX_REDIR_B_OLD = 2'd0;
  localparam logic [1:0] MUX_EX_REDIR_B_EX  = 2'd1;
  localparam logic [1:0] MUX_EX_REDIR_B_DM  = 2'd2;

  localparam logic [1:0] PCTL_DRAIN_CYC = 2'd2;

  typedef enum logic [1:0] {
    PCTL_RUN    = 2'd0,
    PCTL_DRAIN  = 2'd1,
    PCTL_HALTED = 2'd2
  } pctl_state_e;

  // $0 is hardwired to zero, so a write to it never creates a hazard.
  function automatic logic reg_hit(input logic [4:0] req, input logic [4:0] dst,
                                   input logic w_en);
    return w_en && (dst == req) && (req != 5'd0);
  endfunction

endpackage

// File: rtl/syn_pipeline_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: ID/EX/DM hazard inputs
// and the stall/flush/forward controls back to the pipeline registers.
interface syn_pipeline_ctrl_if #(parameter int CNT_W = 16);
  logic             en;
  logic [4:0]       id_req_a;
  logic [4:0]       id_req_b;
  logic             id_use_a;
  logic             id_use_b;
  logic [4:0]       ex_req_w;
  logic             ex_w_en;
  logic             ex_is_load;
  logic [4:0]       dm_req_w;
  logic             dm_w_en;
  logic             load_pc;
  logic             halt_ex;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_clr;
  logic             id_ex_clr;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output en, id_req_a, id_req_b, id_use_a, id_use_b, ex_req_w, ex_w_en,
           ex_is_load, dm_req_w, dm_w_en, load_pc, halt_ex,
    input  pc_en, if_id_en, if_id_clr, id_ex_clr, fwd_a, fwd_b, halted,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  en, id_req_a, id_req_b, id_use_a, id_use_b, ex_req_w, ex_w_en,
           ex_is_load, dm_req_w, dm_w_en, load_pc, halt_ex,
    output pc_en, if_id_en, if_id_clr, id_ex_clr, fwd_a, fwd_b, halted,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/syn_pipeline_ctrl_cmb_fwd_sel.sv
// Forwarding select for one ID source port; the younger EX result wins
// over the older DM result.
module cmb_fwd_sel
  import syn_pipeline_ctrl_pkg::*;
(
  input  logic [4:0] req,
  input  logic [4:0] ex_req_w,
  input  logic       ex_w_en,
  input  logic [4:0] dm_req_w,
  input  logic       dm_w_en,
  output logic [1:0] sel
);

  always_comb begin
    sel = MUX_EX_REDIR_A_OLD;
    if (reg_hit(req, ex_req_w, ex_w_en))
      sel = MUX_EX_REDIR_A_EX;
    else if (reg_hit(req, dm_req_w, dm_w_en))
      sel = MUX_EX_REDIR_A_DM;
  end

endmodule

// File: rtl/syn_pipeline_ctrl.sv
// Hazard/sequencing controller: forwarding selects, load-use stall,
// taken-branch flush and syscall drain/halt with saturating event counters.
//   state        | meaning
//   PCTL_RUN     | normal issue; flush/stall/halt decided per cycle
//   PCTL_DRAIN   | halt seen, letting older instructions retire
//   PCTL_HALTED  | pipeline empty and frozen until reset
module syn_pipeline_ctrl
  import syn_pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  syn_pipeline_ctrl_if.slave bus
);

  pctl_state_e      state, state_nxt;
  logic [1:0]       drain_cnt, drain_nxt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [1:0]       sel_a, sel_b;
  logic             luse, stall_inc, flush_inc;
  logic             pc_en, if_id_en, if_id_clr, id_ex_clr;

  cmb_fwd_sel u_fwd_a (
    .req(bus.id_req_a), .ex_req_w(bus.ex_req_w), .ex_w_en(bus.ex_w_en),
    .dm_req_w(bus.dm_req_w), .dm_w_en(bus.dm_w_en), .sel(sel_a)
  );

  cmb_fwd_sel u_fwd_b (
    .req(bus.id_req_b), .ex_req_w(bus.ex_req_w), .ex_w_en(bus.ex_w_en),
    .dm_req_w(bus.dm_req_w), .dm_w_en(bus.dm_w_en), .sel(sel_b)
  );

  assign luse = bus.ex_is_load && bus.ex_w_en && (bus.ex_req_w != 5'd0) &&
                ((bus.id_use_a && (bus.id_req_a == bus.ex_req_w)) ||
                 (bus.id_use_b && (bus.id_req_b == bus.ex_req_w)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= PCTL_RUN;
      drain_cnt <= 2'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (bus.en) begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    pc_en     = 1'b1;
    if_id_en  = 1'b1;
    if_id_clr = 1'b0;
    id_ex_clr = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    case (state)
      PCTL_RUN: begin
        if (bus.halt_ex) begin
          state_nxt = PCTL_DRAIN;
          drain_nxt = PCTL_DRAIN_CYC;
          pc_en     = 1'b0;
          if_id_clr = 1'b1;
          id_ex_clr = 1'b1;
        end else if (bus.load_pc) begin
          if_id_clr = 1'b1;
          id_ex_clr = 1'b1;
          flush_inc = 1'b1;
        end else if (luse) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_clr = 1'b1;
          stall_inc = 1'b1;
        end
      end
      PCTL_DRAIN: begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        if_id_clr = 1'b1;
        id_ex_clr = 1'b1;
        drain_nxt = drain_cnt - 2'd1;
        // Leave as the count reaches zero so HALTED lands on the drain'th edge.
        if (drain_cnt <= 2'd1) begin
          state_nxt = PCTL_HALTED;
          drain_nxt = 2'd0;
        end
      end
      PCTL_HALTED: begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        if_id_clr = 1'b1;
        id_ex_clr = 1'b1;
      end
      default: state_nxt = PCTL_RUN;
    endcase
  end

  assign bus.pc_en     = rst_n && pc_en;
  assign bus.if_id_en  = rst_n && if_id_en;
  assign bus.if_id_clr = !rst_n || if_id_clr;
  assign bus.id_ex_clr = !rst_n || id_ex_clr;
  assign bus.fwd_a     = rst_n ? sel_a : MUX_EX_REDIR_A_OLD;
  assign bus.fwd_b     = rst_n ? sel_b : MUX_EX_REDIR_B_OLD;
  assign bus.halted    = (state == PCTL_HALTED);
  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_syn_pipeline_ctrl.sv
// Self-checking bench for syn_pipeline_ctrl: vector table, directed
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_syn_pipeline_ctrl;
  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  syn_pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();
  syn_pipeline_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int m_stall = 0, m_flush = 0, m_left = 0;
  bit m_drain = 0, m_halted = 0;

  typedef struct {
    logic [4:0] req_a, req_b;
    logic       use_a, use_b;
    logic [4:0] ex_w;
    logic       ex_en, ex_ld;
    logic [4:0] dm_w;
    logic       dm_en, lpc;
    logic [1:0] e_fa, e_fb;
    logic       e_pc, e_ifid, e_ifclr, e_idclr;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] req);
    if (bus.ex_w_en && req != 0 && bus.ex_req_w == req) return 2'd1;
    if (bus.dm_w_en && req != 0 && bus.dm_req_w == req) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit m_luse();
    if (!(bus.ex_is_load && bus.ex_w_en) || bus.ex_req_w == 0) return 0;
    return (bus.id_use_a && bus.id_req_a == bus.ex_req_w) ||
           (bus.id_use_b && bus.id_req_b == bus.ex_req_w);
  endfunction

  task automatic check_all(input string tag);
    logic pc, ifid, ifclr, idclr;
    logic [1:0] fa, fb;
    fa = m_fwd(bus.id_req_a);
    fb = m_fwd(bus.id_req_b);
    if (!rst_n) begin
      {pc, ifid, ifclr, idclr} = 4'b0011; fa = 0; fb = 0;
    end else if (m_halted || m_drain) {pc, ifid, ifclr, idclr} = 4'b0011;
    else if (bus.halt_ex) {pc, ifid, ifclr, idclr} = 4'b0111;
    else if (bus.load_pc) {pc, ifid, ifclr, idclr} = 4'b1111;
    else if (m_luse())    {pc, ifid, ifclr, idclr} = 4'b0001;
    else                  {pc, ifid, ifclr, idclr} = 4'b1100;
    chk({tag, ".pc_en"}, 32'(bus.pc_en), 32'(pc));
    chk({tag, ".if_id_en"}, 32'(bus.if_id_en), 32'(ifid));
    chk({tag, ".if_id_clr"}, 32'(bus.if_id_clr), 32'(ifclr));
    chk({tag, ".id_ex_clr"}, 32'(bus.id_ex_clr), 32'(idclr));
    chk({tag, ".fwd_a"}, 32'(bus.fwd_a), 32'(fa));
    chk({tag, ".fwd_b"}, 32'(bus.fwd_b), 32'(fb));
    chk({tag, ".halted"}, 32'(bus.halted), 32'(m_halted));
    chk({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(m_stall));
    chk({tag, ".flush_cnt"}, 32'(bus.flush_cnt), 32'(m_flush));
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_stall = 0; m_flush = 0; m_left = 0; m_drain = 0; m_halted = 0;
    end else if (bus.en) begin
      if (m_halted) ;
      else if (m_drain) begin
        m_left--;
        if (m_left == 0) begin m_drain = 0; m_halted = 1; end
      end else if (bus.halt_ex) begin
        m_drain = 1; m_left = 2;
      end else if (bus.load_pc) begin
        if (m_flush < CMAX) m_flush++;
      end else if (m_luse()) begin
        if (m_stall < CMAX) m_stall++;
      end
    end
  endtask

  // inputs were driven at a negedge; check, advance model, wait past the edge
  task automatic step(input string tag);
    #1;
    check_all(tag);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.id_req_a = 0; bus.id_req_b = 0; bus.id_use_a = 0; bus.id_use_b = 0;
    bus.ex_req_w = 0; bus.ex_w_en = 0; bus.ex_is_load = 0;
    bus.dm_req_w = 0; bus.dm_w_en = 0; bus.load_pc = 0; bus.halt_ex = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step("reset");
    rst_n = 1;
  endtask

  initial begin
    bus.en = 1;
    idle_inputs();
    @(negedge clk);
    step("reset_hold");
    rst_n = 1;
    step("after_reset");

    // table: en=0 so outputs are pure combinational decode from RUN
    vecs[0] = '{3,5,1,1, 3,1,0, 0,0,0, 2'd1,2'd0, 1,1,0,0};
    vecs[1] = '{3,5,1,1, 4,1,0, 3,1,0, 2'd2,2'd0, 1,1,0,0};
    vecs[2] = '{3,3,1,1, 3,1,0, 3,1,0, 2'd1,2'd1, 1,1,0,0};
    vecs[3] = '{1,8,1,1, 8,1,1, 0,0,0, 2'd0,2'd1, 0,0,0,1};
    vecs[4] = '{0,9,1,0, 0,1,1, 0,1,0, 2'd0,2'd0, 1,1,0,0};
    vecs[5] = '{1,8,0,1, 8,1,1, 0,0,1, 2'd0,2'd1, 1,1,1,1};
    vecs[6] = '{2,8,1,0, 8,1,1, 8,1,0, 2'd0,2'd1, 1,1,0,0};
    vecs[7] = '{7,7,1,1, 7,0,1, 7,1,0, 2'd2,2'd2, 1,1,0,0};
    vecs[8] = '{6,6,1,1, 6,0,0, 5,1,0, 2'd0,2'd0, 1,1,0,0};
    bus.en = 0;
    for (int i = 0; i < 9; i++) begin
      bus.id_req_a = vecs[i].req_a; bus.id_req_b = vecs[i].req_b;
      bus.id_use_a = vecs[i].use_a; bus.id_use_b = vecs[i].use_b;
      bus.ex_req_w = vecs[i].ex_w;  bus.ex_w_en = vecs[i].ex_en;
      bus.ex_is_load = vecs[i].ex_ld;
      bus.dm_req_w = vecs[i].dm_w;  bus.dm_w_en = vecs[i].dm_en;
      bus.load_pc = vecs[i].lpc;
      #1;
      chk($sformatf("vec%0d.fwd_a", i), 32'(bus.fwd_a), 32'(vecs[i].e_fa));
      chk($sformatf("vec%0d.fwd_b", i), 32'(bus.fwd_b), 32'(vecs[i].e_fb));
      chk($sformatf("vec%0d.pc_en", i), 32'(bus.pc_en), 32'(vecs[i].e_pc));
      chk($sformatf("vec%0d.if_id_en", i), 32'(bus.if_id_en), 32'(vecs[i].e_ifid));
      chk($sformatf("vec%0d.if_id_clr", i), 32'(bus.if_id_clr), 32'(vecs[i].e_ifclr));
      chk($sformatf("vec%0d.id_ex_clr", i), 32'(bus.id_ex_clr), 32'(vecs[i].e_idclr));
      @(negedge clk);
    end
    chk("en0_freeze.stall", 32'(bus.stall_cnt), 32'd0);
    chk("en0_freeze.flush", 32'(bus.flush_cnt), 32'd0);
    bus.en = 1;

    // load-use: lw $8 in EX, ID reads $8 on B; next cycle the load is in DM
    idle_inputs();
    bus.ex_req_w = 8; bus.ex_w_en = 1; bus.ex_is_load = 1;
    bus.id_req_b = 8; bus.id_use_b = 1;
    #1;
    chk("luse.pc_en", 32'(bus.pc_en), 32'd0);
    chk("luse.id_ex_clr", 32'(bus.id_ex_clr), 32'd1);
    step("luse");
    bus.ex_req_w = 0; bus.ex_w_en = 0; bus.ex_is_load = 0;
    bus.dm_req_w = 8; bus.dm_w_en = 1;
    #1;
    chk("luse_next.fwd_b", 32'(bus.fwd_b), 32'd2);
    chk("luse_next.stall_cnt", 32'(bus.stall_cnt), 32'd1);
    chk("luse_next.pc_en", 32'(bus.pc_en), 32'd1);
    step("luse_next");

    // flush and load-use together: flush wins, no stall counted
    idle_inputs();
    do_reset();
    bus.ex_req_w = 8; bus.ex_w_en = 1; bus.ex_is_load = 1;
    bus.id_req_b = 8; bus.id_use_b = 1; bus.load_pc = 1;
    step("flush_luse");
    idle_inputs();
    #1;
    chk("flush_luse.flush_cnt", 32'(bus.flush_cnt), 32'd1);
    chk("flush_luse.stall_cnt", 32'(bus.stall_cnt), 32'd0);
    step("flush_luse_after");

    // halt: asserted in cycle c, DRAIN for two cycles, halted on c+3
    bus.halt_ex = 1;
    #1;
    chk("halt.c0.pc_en", 32'(bus.pc_en), 32'd0);
    step("halt_c0");
    bus.halt_ex = 0;
    bus.load_pc = 1;
    #1;
    chk("halt.c1.halted", 32'(bus.halted), 32'd0);
    chk("halt.c1.pc_en", 32'(bus.pc_en), 32'd0);
    step("halt_c1");
    #1;
    chk("halt.c2.halted", 32'(bus.halted), 32'd0);
    step("halt_c2");
    #1;
    chk("halt.c3.halted", 32'(bus.halted), 32'd1);
    chk("halt.c3.flush_cnt", 32'(bus.flush_cnt), 32'd1);
    step("halt_c3");
    step("halt_c4");
    rst_n = 0;
    #1;
    chk("rst_in_halt.pc_en", 32'(bus.pc_en), 32'd0);
    chk("rst_in_halt.if_id_clr", 32'(bus.if_id_clr), 32'd1);
    step("rst_in_halt");
    rst_n = 1;
    bus.load_pc = 0;
    #1;
    chk("post_rst.halted", 32'(bus.halted), 32'd0);
    chk("post_rst.flush_cnt", 32'(bus.flush_cnt), 32'd0);
    chk("post_rst.pc_en", 32'(bus.pc_en), 32'd1);
    step("post_rst");

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst_n          = ($urandom_range(0, 29) != 0);
      bus.en         = ($urandom_range(0, 7) != 0);
      bus.id_req_a   = 5'($urandom_range(0, 3));
      bus.id_req_b   = 5'($urandom_range(0, 3));
      bus.id_use_a   = 1'($urandom);
      bus.id_use_b   = 1'($urandom);
      bus.ex_req_w   = 5'($urandom_range(0, 3));
      bus.ex_w_en    = 1'($urandom);
      bus.ex_is_load = 1'($urandom);
      bus.dm_req_w   = 5'($urandom_range(0, 3));
      bus.dm_w_en    = 1'($urandom);
      bus.load_pc    = ($urandom_range(0, 3) == 0);
      bus.halt_ex    = ($urandom_range(0, 39) == 0);
      step("rand");
    end

    // saturation of flush_cnt
    rst_n = 1; bus.en = 1;
    idle_inputs();
    do_reset();
    bus.load_pc = 1;
    repeat (70000) begin
      model_edge();
      @(negedge clk);
    end
    #1;
    chk("sat.flush_cnt", 32'(bus.flush_cnt), 32'hFFFF);
    step("sat");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
